// File: rtl/vram_fetch_pkg.sv
// -----------------------------------------------------------------------------
// vram_fetch_pkg
// Shared definitions for the screen-line VRAM fetcher: FSM state encoding,
// screen geometry constants and the SRAM address formation helpers.
// -----------------------------------------------------------------------------
package vram_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_ROOM  = 3'd1,
        ISSUE_BMP  = 3'd2,
        WAIT_BMP   = 3'd3,
        ISSUE_ATTR = 3'd4,
        WAIT_ATTR  = 3'd5,
        PUSH       = 3'd6
    } state_e;

    localparam int unsigned SCREEN_LINES   = 192;
    localparam int unsigned BYTES_PER_LINE = 32;
    localparam logic [12:0] ATTR_OFFSET    = 13'h1800;

    // Bitmap rows are interleaved: thirds, then pixel row, then character row.
    function automatic logic [18:0] bmp_addr(input logic [4:0] page,
                                             input logic [7:0] y,
                                             input logic [4:0] x);
        return {page, 1'b0, y[7:6], y[2:0], y[5:3], x};
    endfunction

    // Attributes are one byte per 8x8 cell, placed after the bitmap area.
    function automatic logic [18:0] attr_addr(input logic [4:0] page,
                                              input logic [4:0] cell_row,
                                              input logic [4:0] x);
        return {page, 1'b0, ATTR_OFFSET | {3'b000, cell_row, x}};
    endfunction

endpackage

// File: rtl/vram_fetch_fifo.sv
// -----------------------------------------------------------------------------
// pair_fifo
// Small synchronous FIFO of 16-bit {bitmap, attribute} pairs.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (flushes the FIFO)
//   push_i/wdata_i: write request and data (ignored when full)
//   pop_i         : consumer takes the head entry (ignored when empty)
//   rdata_o       : head entry, zero while empty
//   valid_o       : FIFO not empty
//   full_o        : FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module pair_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [15:0] wdata_i,
    input  logic        pop_i,
    output logic [15:0] rdata_o,
    output logic        valid_o,
    output logic        full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o    = (cnt_q == (AW + 1)'(DEPTH));
    assign valid_o   = (cnt_q != {(AW + 1){1'b0}});
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && valid_o;
    assign rdata_o   = valid_o ? mem_q[rd_q] : 16'h0000;

    // Storage array; contents only matter behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_q <= wr_q + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_q <= rd_q + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + {{AW{1'b0}}, 1'b1};
                2'b01:   cnt_q <= cnt_q - {{AW{1'b0}}, 1'b1};
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vram_fetch.sv
// -----------------------------------------------------------------------------
// vram_fetch
// Fetches one screen line (32 bitmap/attribute byte pairs) from SRAM port 2
// into a small FIFO for the video shifter.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   line_go/line_y/page   : start request, screen row and SRAM page
//   a2, oe2_n, we2_n, din2: SRAM port-2 address/control (read-only client)
//   dout2                 : SRAM read data, valid RD_LAT cycles after a2
//   pop, valid            : FIFO handshake
//   bitmap_out, attr_out  : FIFO head entry
//   busy, line_done, overrun : status; pulses are one cycle wide
// -----------------------------------------------------------------------------
module vram_fetch
    import vram_fetch_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_go,
    input  logic [7:0]  line_y,
    input  logic [4:0]  page,
    output logic [18:0] a2,
    output logic        oe2_n,
    output logic        we2_n,
    output logic [7:0]  din2,
    input  logic [7:0]  dout2,
    input  logic        pop,
    output logic        valid,
    output logic [7:0]  bitmap_out,
    output logic [7:0]  attr_out,
    output logic        busy,
    output logic        line_done,
    output logic        overrun
);
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [4:0] X_LAST   = 5'(BYTES_PER_LINE - 1);
    localparam logic [7:0] Y_LIMIT  = 8'(SCREEN_LINES);

    state_e      state_q;
    logic [4:0]  x_q;
    logic [7:0]  y_q;
    logic [4:0]  page_q;
    logic [2:0]  lat_q;
    logic [7:0]  bmp_q;
    logic [7:0]  attr_q;
    logic [18:0] a2_q;
    logic        oe2_n_q;
    logic        line_done_q;
    logic        overrun_q;
    logic        fifo_full_s;
    logic        push_s;
    logic [15:0] head_s;

    assign a2         = a2_q;
    assign oe2_n      = oe2_n_q;
    assign we2_n      = 1'b1;
    assign din2       = 8'h00;
    assign busy       = (state_q != IDLE);
    assign line_done  = line_done_q;
    assign overrun    = overrun_q;
    assign push_s     = (state_q == PUSH);
    assign bitmap_out = head_s[15:8];
    assign attr_out   = head_s[7:0];

    pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i ({bmp_q, attr_q}),
        .pop_i   (pop),
        .rdata_o (head_s),
        .valid_o (valid),
        .full_o  (fifo_full_s)
    );

    // Fetch sequencer. a2/oe2_n are loaded on entry to ISSUE_* so they are
    // stable through ISSUE and WAIT; WAIT lasts RD_LAT cycles after ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= 5'd0;
            y_q         <= 8'd0;
            page_q      <= 5'd0;
            lat_q       <= 3'd0;
            bmp_q       <= 8'h00;
            attr_q      <= 8'h00;
            a2_q        <= 19'd0;
            oe2_n_q     <= 1'b1;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            overrun_q   <= line_go && ((state_q != IDLE) || (line_y >= Y_LIMIT));
            case (state_q)
                IDLE: begin
                    if (line_go && (line_y < Y_LIMIT)) begin
                        y_q     <= line_y;
                        page_q  <= page;
                        x_q     <= 5'd0;
                        state_q <= WAIT_ROOM;
                    end
                end
                WAIT_ROOM: begin
                    if (!fifo_full_s) begin
                        a2_q    <= bmp_addr(page_q, y_q, x_q);
                        oe2_n_q <= 1'b0;
                        state_q <= ISSUE_BMP;
                    end
                end
                ISSUE_BMP: begin
                    lat_q   <= 3'd0;
                    state_q <= WAIT_BMP;
                end
                WAIT_BMP: begin
                    if (lat_q == LAT_LAST) begin
                        bmp_q   <= dout2;
                        a2_q    <= attr_addr(page_q, y_q[7:3], x_q);
                        state_q <= ISSUE_ATTR;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                ISSUE_ATTR: begin
                    lat_q   <= 3'd0;
                    state_q <= WAIT_ATTR;
                end
                WAIT_ATTR: begin
                    if (lat_q == LAT_LAST) begin
                        attr_q  <= dout2;
                        a2_q    <= 19'd0;
                        oe2_n_q <= 1'b1;
                        state_q <= PUSH;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                PUSH: begin
                    x_q <= x_q + 5'd1;
                    if (x_q == X_LAST) begin
                        line_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= WAIT_ROOM;
                    end
                end
                default: begin
                    a2_q    <= 19'd0;
                    oe2_n_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fetch.sv
// -----------------------------------------------------------------------------
// tb_vram_fetch
// Directed bench for vram_fetch with an SRAM model whose read data is the low
// byte of the address presented RD_LAT cycles earlier.
// -----------------------------------------------------------------------------
module tb_vram_fetch;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_go;
    logic [7:0]  line_y;
    logic [4:0]  page;
    logic [18:0] a2;
    logic        oe2_n;
    logic        we2_n;
    logic [7:0]  din2;
    logic [7:0]  dout2;
    logic        pop;
    logic        valid;
    logic [7:0]  bitmap_out;
    logic [7:0]  attr_out;
    logic        busy;
    logic        line_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    logic [18:0] addr_q [$];
    logic [15:0] pair_q [$];
    logic [18:0] pipe_q [LAT];

    always #5 clk = ~clk;

    vram_fetch #(.RD_LAT(LAT), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_go    (line_go),
        .line_y     (line_y),
        .page       (page),
        .a2         (a2),
        .oe2_n      (oe2_n),
        .we2_n      (we2_n),
        .din2       (din2),
        .dout2      (dout2),
        .pop        (pop),
        .valid      (valid),
        .bitmap_out (bitmap_out),
        .attr_out   (attr_out),
        .busy       (busy),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    // SRAM read pipeline: data for an address appears LAT edges later.
    always @(posedge clk) begin
        pipe_q[0] <= a2;
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i - 1];
        end
    end
    assign dout2 = pipe_q[LAT - 1][7:0];

    // Observer: records each read issue, each popped pair and status pulses.
    initial begin
        logic        prev_oe;
        logic [18:0] prev_a2;
        prev_oe = 1'b1;
        prev_a2 = 19'd0;
        forever begin
            @(negedge clk);
            if (!oe2_n && (prev_oe || (a2 != prev_a2))) addr_q.push_back(a2);
            prev_oe = oe2_n;
            prev_a2 = a2;
            if (valid && pop) pair_q.push_back({bitmap_out, attr_out});
            if (line_done) done_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_bmp(input int pg, input int y, input int x);
        return (pg << 14) | (((y >> 6) & 3) << 11) | ((y & 7) << 8) | (((y >> 3) & 7) << 5) | x;
    endfunction

    function automatic int exp_attr(input int pg, input int y, input int x);
        return (pg << 14) | 32'h1800 | ((y >> 3) << 5) | x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int pg, input int y);
        page    = 5'(pg);
        line_y  = 8'(y);
        line_go = 1'b1;
        tick();
        line_go = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while ((done_cnt == start) && (n < 2000)) begin
            tick();
            n++;
        end
        if (done_cnt == start) chk("line_done_timeout", 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    task automatic check_line(input int pg, input int y);
        chk("addr_count", 32'(addr_q.size()), 32'd64);
        chk("pair_count", 32'(pair_q.size()), 32'd32);
        for (int x = 0; x < 32; x++) begin
            if (2 * x + 1 < addr_q.size()) begin
                chk("bmp_a2", 32'(addr_q[2 * x]), 32'(exp_bmp(pg, y, x)));
                chk("attr_a2", 32'(addr_q[2 * x + 1]), 32'(exp_attr(pg, y, x)));
            end
            if (x < pair_q.size()) begin
                chk("pair", 32'(pair_q[x]),
                    32'({exp_bmp(pg, y, x) & 255, 8'(exp_attr(pg, y, x) & 255)}) & 32'hFFFF);
            end
        end
    endtask

    initial begin
        int d0;
        int n;
        rst = 1'b1; line_go = 1'b0; line_y = 8'd0; page = 5'd0; pop = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(line_done), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_oe", 32'(oe2_n), 32'd1);
        chk("rst_a2", 32'(a2), 32'd0);
        chk("rst_bmp", 32'(bitmap_out), 32'd0);
        chk("rst_attr", 32'(attr_out), 32'd0);
        chk("we2_n", 32'(we2_n), 32'd1);
        chk("din2", 32'(din2), 32'd0);
        rst = 1'b0;
        tick();

        // Basic line, page 5 row 0, consumer always ready.
        pop = 1'b1;
        addr_q.delete(); pair_q.delete(); d0 = done_cnt;
        go(5, 0);
        wait_done(d0);
        chk("first_bmp", addr_q.size() > 0 ? 32'(addr_q[0]) : 32'd0, 32'h14000);
        chk("first_attr", addr_q.size() > 1 ? 32'(addr_q[1]) : 32'd0, 32'h15800);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        check_line(5, 0);

        // Row 65: last cell addresses.
        addr_q.delete(); pair_q.delete(); d0 = done_cnt;
        go(5, 65);
        wait_done(d0);
        chk("y65_bmp31", addr_q.size() > 62 ? 32'(addr_q[62]) : 32'd0, 32'h1491F);
        chk("y65_attr31", addr_q.size() > 63 ? 32'(addr_q[63]) : 32'd0, 32'h1591F);
        check_line(5, 65);

        // Back-pressure: no pops, FIFO fills after 4 pairs.
        pop = 1'b0;
        addr_q.delete(); pair_q.delete(); d0 = done_cnt;
        go(3, 100);
        repeat (200) tick();
        chk("bp_issues", 32'(addr_q.size()), 32'd8);
        chk("bp_oe", 32'(oe2_n), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_valid", 32'(valid), 32'd1);
        chk("bp_head_bmp", 32'(bitmap_out), 32'(exp_bmp(3, 100, 0) & 255));
        chk("bp_head_attr", 32'(attr_out), 32'(exp_attr(3, 100, 0) & 255));
        pop = 1'b1;
        wait_done(d0);
        check_line(3, 100);

        // Rejected requests: while busy, then with row 200 while idle.
        addr_q.delete(); pair_q.delete(); d0 = done_cnt; ovr_cnt = 0;
        go(6, 10);
        repeat (20) tick();
        go(7, 50);
        wait_done(d0);
        chk("ovr_busy", 32'(ovr_cnt), 32'd1);
        check_line(6, 10);
        addr_q.delete(); pair_q.delete();
        go(6, 200);
        repeat (10) tick();
        chk("ovr_y200", 32'(ovr_cnt), 32'd2);
        chk("y200_busy", 32'(busy), 32'd0);
        chk("y200_issues", 32'(addr_q.size()), 32'd0);

        // Reset mid-line at x = 10.
        addr_q.delete(); pair_q.delete(); d0 = done_cnt;
        go(2, 20);
        n = 0;
        while ((addr_q.size() < 21) && (n < 1000)) begin
            tick();
            n++;
        end
        chk("reach_x10", 32'(addr_q.size() >= 21), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_oe", 32'(oe2_n), 32'd1);
        repeat (50) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        addr_q.delete(); pair_q.delete(); d0 = done_cnt;
        go(2, 20);
        wait_done(d0);
        check_line(2, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
